// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin arbitration with packet-level
// locking, zero-cycle allocation latency and crossbar/grant generation.
module switch_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int PW        = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PORTS-1:0]    req_valid,
    input  logic [NUM_PORTS*PW-1:0] req_outport,
    input  logic [NUM_PORTS-1:0]    req_tail,
    input  logic [NUM_PORTS-1:0]    out_ready,
    output logic [NUM_PORTS-1:0]    in_grant,
    output logic [NUM_PORTS*PW-1:0] xbar_sel,
    output logic [NUM_PORTS-1:0]    out_valid,
    output logic [NUM_PORTS-1:0]    out_locked,
    output logic                    proto_err
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e         fsm_q    [NUM_PORTS];
    logic [PW-1:0]  owner_q  [NUM_PORTS];
    logic [PW-1:0]  rr_ptr_q [NUM_PORTS];
    logic           proto_err_q;

    logic [NUM_PORTS-1:0] hit [NUM_PORTS];
    logic [PW-1:0]        cand [NUM_PORTS];
    logic [NUM_PORTS-1:0] found;
    logic [NUM_PORTS-1:0] xfer;
    logic [NUM_PORTS-1:0] xfer_tail;
    logic [NUM_PORTS-1:0] proto_set;

    always_comb begin : arbitrate
        int idx;
        idx = 0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            // NOTE: every combinational output gets a default before any branch so no latch is inferred.
            found[o]     = 1'b0;
            cand[o]      = '0;
            xfer_tail[o] = 1'b0;
            proto_set[o] = 1'b0;
            hit[o]       = '0;

            // NONE codes (>= NUM_PORTS) never match any o, so they never request.
            for (int i = 0; i < NUM_PORTS; i++) begin
                hit[o][i] = req_valid[i] && (req_outport[i*PW +: PW] == PW'(o));
            end

            if (fsm_q[o] == LOCKED) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (owner_q[o] == PW'(i)) begin
                        found[o]     = hit[o][i];
                        cand[o]      = PW'(i);
                        proto_set[o] = req_valid[i] && !hit[o][i];
                    end
                end
            end else begin
                for (int k = 1; k <= NUM_PORTS; k++) begin
                    idx = (int'(rr_ptr_q[o]) + k) % NUM_PORTS;
                    if (!found[o] && hit[o][idx]) begin
                        found[o] = 1'b1;
                        cand[o]  = PW'(idx);
                    end
                end
            end

            xfer[o] = found[o] && out_ready[o];
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (cand[o] == PW'(i)) xfer_tail[o] = req_tail[i];
            end
        end
    end

    // Grant outputs are combinational but held at zero while reset is asserted.
    always_comb begin : drive_outputs
        in_grant  = '0;
        out_valid = '0;
        xbar_sel  = '0;
        if (rst_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (xfer[o]) begin
                    out_valid[o]          = 1'b1;
                    xbar_sel[o*PW +: PW]  = cand[o];
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (cand[o] == PW'(i)) in_grant[i] = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                fsm_q[o]    <= IDLE;
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= PW'(NUM_PORTS - 1);
            end
            proto_err_q <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (xfer[o]) begin
                    case (fsm_q[o])
                        IDLE: begin
                            rr_ptr_q[o] <= cand[o];
                            if (!xfer_tail[o]) begin
                                fsm_q[o]   <= LOCKED;
                                owner_q[o] <= cand[o];
                            end
                        end
                        LOCKED: begin
                            if (xfer_tail[o]) fsm_q[o] <= IDLE;
                        end
                        default: fsm_q[o] <= IDLE;
                    endcase
                end
            end
            if (|proto_set) proto_err_q <= 1'b1;
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_locked[o] = (fsm_q[o] == LOCKED);
        end
    end

    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: a vector table for arbitration cases plus
// hand-written sequences for locking, stalls, protocol errors and mid-packet reset.
module tb_switch_allocator;

    localparam int N  = 5;
    localparam int PW = 3;
    localparam int NONE = 7;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*PW-1:0] req_outport;
    logic [N-1:0]   req_tail;
    logic [N-1:0]   out_ready;
    logic [N-1:0]   in_grant;
    logic [N*PW-1:0] xbar_sel;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_locked;
    logic           proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    switch_allocator #(.NUM_PORTS(N), .PW(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_outport(req_outport),
        .req_tail   (req_tail),
        .out_ready  (out_ready),
        .in_grant   (in_grant),
        .xbar_sel   (xbar_sel),
        .out_valid  (out_valid),
        .out_locked (out_locked),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    v;
        logic [N*PW-1:0] op;
        logic [N-1:0]    t;
        logic [N-1:0]    r;
        logic [N-1:0]    g;
        logic [N-1:0]    ov;
        logic [N*PW-1:0] xs;
        logic [N-1:0]    lk;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*PW-1:0] ports(input int p0, input int p1, input int p2,
                                               input int p3, input int p4);
        return {PW'(p4), PW'(p3), PW'(p2), PW'(p1), PW'(p0)};
    endfunction

    // Drive inputs just after the falling edge; outputs are then sampled 2 time units later.
    task automatic drive(input logic [N-1:0] v, input logic [N*PW-1:0] op,
                         input logic [N-1:0] t, input logic [N-1:0] r);
        @(negedge clk);
        req_valid   = v;
        req_outport = op;
        req_tail    = t;
        out_ready   = r;
        #2;
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] g, input logic [N-1:0] ov,
                              input logic [N*PW-1:0] xs, input logic [N-1:0] lk);
        check({tag, " in_grant"},   32'(in_grant),   32'(g));
        check({tag, " out_valid"},  32'(out_valid),  32'(ov));
        check({tag, " xbar_sel"},   32'(xbar_sel),   32'(xs));
        check({tag, " out_locked"}, 32'(out_locked), 32'(lk));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n       = 1'b0;
        req_valid   = '1;
        req_outport = ports(0, 0, 0, 0, 0);
        req_tail    = '0;
        out_ready   = '1;
        #2;
        check("reset in_grant",   32'(in_grant),   0);
        check("reset out_valid",  32'(out_valid),  0);
        check("reset out_locked", 32'(out_locked), 0);
        check("reset proto_err",  32'(proto_err),  0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_outport = '0;
        req_tail    = '0;
        out_ready   = '0;

        vecs[0] = '{5'b01010, ports(NONE, 2, NONE, 2, NONE), 5'b11111, 5'b11111,
                    5'b00010, 5'b00100, ports(0, 0, 1, 0, 0), 5'b00000};
        vecs[1] = '{5'b01010, ports(NONE, 2, NONE, 2, NONE), 5'b11111, 5'b11111,
                    5'b01000, 5'b00100, ports(0, 0, 3, 0, 0), 5'b00000};
        vecs[2] = '{5'b01010, ports(NONE, 2, NONE, 2, NONE), 5'b11111, 5'b11111,
                    5'b00010, 5'b00100, ports(0, 0, 1, 0, 0), 5'b00000};
        vecs[3] = '{5'b01010, ports(NONE, 2, NONE, 2, NONE), 5'b11111, 5'b11111,
                    5'b01000, 5'b00100, ports(0, 0, 3, 0, 0), 5'b00000};
        vecs[4] = '{5'b01011, ports(2, 4, NONE, 0, NONE), 5'b11111, 5'b11111,
                    5'b01011, 5'b10101, ports(3, 0, 0, 0, 1), 5'b00000};
        vecs[5] = '{5'b00001, ports(NONE, NONE, NONE, NONE, NONE), 5'b11111, 5'b11111,
                    5'b00000, 5'b00000, ports(0, 0, 0, 0, 0), 5'b00000};
        vecs[6] = '{5'b00100, ports(NONE, NONE, 1, NONE, NONE), 5'b11111, 5'b11101,
                    5'b00000, 5'b00000, ports(0, 0, 0, 0, 0), 5'b00000};
        vecs[7] = '{5'b00100, ports(NONE, NONE, 1, NONE, NONE), 5'b11111, 5'b11111,
                    5'b00100, 5'b00010, ports(0, 2, 0, 0, 0), 5'b00000};
        vecs[8] = '{5'b00110, ports(NONE, 1, 1, NONE, NONE), 5'b11111, 5'b11111,
                    5'b00010, 5'b00010, ports(0, 1, 0, 0, 0), 5'b00000};

        reset_dut();

        for (int k = 0; k < 9; k++) begin
            drive(vecs[k].v, vecs[k].op, vecs[k].t, vecs[k].r);
            expect_out($sformatf("vec%0d", k), vecs[k].g, vecs[k].ov, vecs[k].xs, vecs[k].lk);
        end

        // 4-flit packet from input 0 holds output 4 against input 2.
        reset_dut();
        drive(5'b00001, ports(4, NONE, NONE, NONE, NONE), 5'b00000, 5'b11111);
        expect_out("lock H", 5'b00001, 5'b10000, ports(0, 0, 0, 0, 0), 5'b00000);
        drive(5'b00101, ports(4, NONE, 4, NONE, NONE), 5'b00100, 5'b11111);
        expect_out("lock B1", 5'b00001, 5'b10000, ports(0, 0, 0, 0, 0), 5'b10000);
        drive(5'b00101, ports(4, NONE, 4, NONE, NONE), 5'b00100, 5'b11111);
        expect_out("lock B2", 5'b00001, 5'b10000, ports(0, 0, 0, 0, 0), 5'b10000);
        drive(5'b00101, ports(4, NONE, 4, NONE, NONE), 5'b00101, 5'b11111);
        expect_out("lock T", 5'b00001, 5'b10000, ports(0, 0, 0, 0, 0), 5'b10000);
        drive(5'b00100, ports(NONE, NONE, 4, NONE, NONE), 5'b00100, 5'b11111);
        expect_out("lock next", 5'b00100, 5'b10000, ports(0, 0, 0, 0, 2), 5'b00000);

        // Downstream stall on a locked output; a competing input must stay blocked.
        reset_dut();
        drive(5'b01000, ports(NONE, NONE, NONE, 1, NONE), 5'b00000, 5'b11111);
        expect_out("stall H", 5'b01000, 5'b00010, ports(0, 3, 0, 0, 0), 5'b00000);
        for (int k = 0; k < 3; k++) begin
            drive(5'b01001, ports(1, NONE, NONE, 1, NONE), 5'b00001, 5'b11101);
            expect_out($sformatf("stall s%0d", k), 5'b00000, 5'b00000, ports(0, 0, 0, 0, 0), 5'b00010);
        end
        drive(5'b01001, ports(1, NONE, NONE, 1, NONE), 5'b00001, 5'b11111);
        expect_out("stall B", 5'b01000, 5'b00010, ports(0, 3, 0, 0, 0), 5'b00010);
        drive(5'b01001, ports(1, NONE, NONE, 1, NONE), 5'b01001, 5'b11111);
        expect_out("stall T", 5'b01000, 5'b00010, ports(0, 3, 0, 0, 0), 5'b00010);
        drive(5'b00001, ports(1, NONE, NONE, NONE, NONE), 5'b00001, 5'b11111);
        expect_out("stall next", 5'b00001, 5'b00010, ports(0, 0, 0, 0, 0), 5'b00000);

        // Owner of output 3 retargets mid-packet.
        reset_dut();
        drive(5'b00100, ports(NONE, NONE, 3, NONE, NONE), 5'b00000, 5'b11111);
        expect_out("perr H", 5'b00100, 5'b01000, ports(0, 0, 0, 2, 0), 5'b00000);
        check("perr before", 32'(proto_err), 0);
        drive(5'b00100, ports(NONE, NONE, 1, NONE, NONE), 5'b00000, 5'b11101);
        expect_out("perr bad", 5'b00000, 5'b00000, ports(0, 0, 0, 0, 0), 5'b01000);
        check("perr same cycle", 32'(proto_err), 0);
        drive(5'b00000, ports(NONE, NONE, NONE, NONE, NONE), 5'b00000, 5'b11111);
        check("perr set", 32'(proto_err), 1);
        check("perr lock kept", 32'(out_locked), 32'(5'b01000));
        drive(5'b00000, ports(NONE, NONE, NONE, NONE, NONE), 5'b00000, 5'b11111);
        check("perr sticky", 32'(proto_err), 1);

        // Reset mid-packet drops the lock and restores input 0's priority.
        reset_dut();
        drive(5'b00001, ports(2, NONE, NONE, NONE, NONE), 5'b00000, 5'b11111);
        expect_out("rst H", 5'b00001, 5'b00100, ports(0, 0, 0, 0, 0), 5'b00000);
        @(negedge clk);
        rst_n       = 1'b0;
        req_valid   = 5'b00011;
        req_outport = ports(2, 2, NONE, NONE, NONE);
        req_tail    = 5'b00011;
        out_ready   = '1;
        #2;
        expect_out("rst during", 5'b00000, 5'b00000, ports(0, 0, 0, 0, 0), 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        expect_out("rst after", 5'b00001, 5'b00100, ports(0, 0, 0, 0, 0), 5'b00000);
        check("rst proto_err", 32'(proto_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
